// File: rtl/bpsk_modulator.sv
// BPSK modulator: keys a free-running carrier (sine / negated sine) with a serial
// MSB-first bit stream, switching bits only on carrier phase-alignment cycles.
module bpsk_modulator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int PHASE_ALIGN   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             carrier_valid,
  input  logic [SAMPLE_WIDTH-1:0]          sine_in,
  input  logic [SAMPLE_WIDTH-1:0]          neg_sine_in,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] phase_cnt,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             data_valid,
  output logic                             data_ready,
  output logic [SAMPLE_WIDTH-1:0]          mod_out,
  output logic                             mod_valid,
  output logic                             busy,
  output logic                             frame_done,
  output logic [1:0]                       dbg_state
);

  localparam int PW = $clog2(SAMPLE_NUMBER);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PW-1:0]           ALIGN_PH = PW'(PHASE_ALIGN);
  localparam logic [BW-1:0]           LAST_IDX = BW'(DATA_WIDTH - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [BW-1:0]           bit_idx_q, bit_idx_d;
  logic [SAMPLE_WIDTH-1:0] mod_out_q, mod_out_d;
  logic                    mod_valid_q, mod_valid_d;
  logic                    frame_done_q, frame_done_d;

  logic                    boundary;
  logic [DATA_WIDTH-1:0]   shifted;

  assign boundary = carrier_valid && (phase_cnt == ALIGN_PH);
  assign shifted  = shift_q << 1;

  // Handshake: a word transfers on a rising edge where data_valid && data_ready;
  // data_ready is high throughout IDLE and only on the final-bit boundary cycle
  // of SEND, so a following word can be chained without a gap.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    mod_out_d    = mod_out_q;
    mod_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    data_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        data_ready = 1'b1;
        mod_out_d  = MIDSCALE;
        if (data_valid) begin
          shift_d   = data_in;
          bit_idx_d = '0;
          state_d   = ALIGN;
        end
      end
      ALIGN: begin
        mod_out_d = MIDSCALE;
        if (boundary) begin
          state_d     = SEND;
          mod_valid_d = 1'b1;
          mod_out_d   = shift_q[DATA_WIDTH-1] ? neg_sine_in : sine_in;
        end
      end
      SEND: begin
        if (carrier_valid) begin
          mod_valid_d = 1'b1;
          mod_out_d   = shift_q[DATA_WIDTH-1] ? neg_sine_in : sine_in;
          if (boundary) begin
            if (bit_idx_q != LAST_IDX) begin
              shift_d   = shifted;
              bit_idx_d = bit_idx_q + BW'(1);
              mod_out_d = shifted[DATA_WIDTH-1] ? neg_sine_in : sine_in;
            end else begin
              data_ready = 1'b1;
              if (data_valid) begin
                shift_d   = data_in;
                bit_idx_d = '0;
                mod_out_d = data_in[DATA_WIDTH-1] ? neg_sine_in : sine_in;
              end else begin
                state_d      = IDLE;
                shift_d      = '0;
                bit_idx_d    = '0;
                mod_out_d    = MIDSCALE;
                mod_valid_d  = 1'b0;
                frame_done_d = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mod_out_d = MIDSCALE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      mod_out_q    <= MIDSCALE;
      mod_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      mod_out_q    <= mod_out_d;
      mod_valid_q  <= mod_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mod_out    = mod_out_q;
  assign mod_valid  = mod_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: doc/bpsk_modulator.md
BPSK_MODULATOR -- requirements
Module: bpsk_modulator

Interface
REQ-001 SHALL have parameter SAMPLE_NUMBER, default 256, carrier samples per period = samples per data bit.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 12, unsigned offset-binary sample width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, bits per accepted word.
REQ-004 SHALL have parameter PHASE_ALIGN, default 1, phase_cnt value at which sine_in carries carrier sample 0.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port carrier_valid  input  1  carrier source advanced this cycle (its enable).
REQ-008 SHALL have port sine_in  input  SAMPLE_WIDTH  carrier sample, phase 0.
REQ-009 SHALL have port neg_sine_in  input  SAMPLE_WIDTH  carrier sample, phase 180.
REQ-010 SHALL have port phase_cnt  input  $clog2(SAMPLE_NUMBER)  carrier source sample counter.
REQ-011 SHALL have port data_in  input  DATA_WIDTH  word to transmit, MSB first.
REQ-012 SHALL have port data_valid  input  1  data_in valid.
REQ-013 SHALL have port data_ready  output  1  word accepted when data_valid && data_ready at a rising edge.
REQ-014 SHALL have port mod_out  output  SAMPLE_WIDTH  registered BPSK sample.
REQ-015 SHALL have port mod_valid  output  1  one-cycle strobe, new sample on mod_out.
REQ-016 SHALL have port busy  output  1  high in ALIGN and SEND.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse when the last bit of the last queued word finishes.

Function
REQ-018 SHALL define boundary = carrier_valid && (phase_cnt == PHASE_ALIGN); all bit changes occur only on boundary cycles.
REQ-019 SHALL implement FSM states IDLE, ALIGN, SEND; reset state IDLE.
REQ-020 IDLE: data_ready=1; on data_valid capture data_in into shift register, bit_idx=0, go ALIGN.
REQ-021 ALIGN: data_ready=0; mod_valid=0; on boundary go SEND and register first sample of MSB.
REQ-022 SEND: on every carrier_valid cycle register mod_out = (current bit ? neg_sine_in : sine_in), mod_valid=1; bit 0 -> sine, bit 1 -> neg_sine.
REQ-023 SEND, boundary with bit_idx < DATA_WIDTH-1: shift, bit_idx+1; registered sample uses the new bit.
REQ-024 SEND, boundary with bit_idx == DATA_WIDTH-1: data_ready=1 combinationally this cycle only; if data_valid, load new word, bit_idx=0, stay SEND, output new MSB sample (no gap); else go IDLE, mod_out=2^(SAMPLE_WIDTH-1), mod_valid=0, frame_done=1.
REQ-025 carrier_valid low: mod_out holds, mod_valid=0, state/bit_idx unchanged.
REQ-026 Each bit SHALL last exactly SAMPLE_NUMBER mod_valid strobes; word lasts DATA_WIDTH*SAMPLE_NUMBER strobes.
REQ-027 IDLE/ALIGN mod_out SHALL be midscale 2^(SAMPLE_WIDTH-1).
REQ-028 data_in changes while not ready SHALL be ignored; no word accepted in ALIGN or mid-word.
REQ-029 Word accepted in IDLE on a boundary cycle SHALL still wait for the next boundary (ALIGN entered).

Reset
REQ-030 rst high SHALL asynchronously force IDLE, mod_out=2^(SAMPLE_WIDTH-1), mod_valid=0, frame_done=0, busy=0, bit_idx=0, shift register 0.
REQ-031 Reset mid-word SHALL abandon the word; first post-reset accepted word starts from its MSB.

Verification (SAMPLE_NUMBER=8, SAMPLE_WIDTH=12, DATA_WIDTH=8, PHASE_ALIGN=1, carrier_valid=1 continuous)
REQ-032 Send 8'hA5 from IDLE -> ALIGN until phase_cnt==1, then 64 strobes with per-bit phase 1,0,1,0,0,1,0,1 (neg,sine,neg,sine,sine,neg,sine,neg); frame_done one pulse; mod_out=12'h800 after.
REQ-033 Back-to-back 8'hFF then 8'h00 with data_valid held -> second word accepted at the 64th-strobe boundary, 128 contiguous strobes, no midscale gap, single frame_done.
REQ-034 carrier_valid toggled 1/0 every cycle during 8'h3C -> exactly 64 strobes, bit changes only on phase_cnt==1 strobes, outputs held on idle cycles.
REQ-035 rst asserted at strobe 20 of 8'hF0 -> same-cycle-asynchronous mod_out=12'h800, mod_valid=0, busy=0; next word 8'h81 transmitted intact from MSB.
REQ-036 data_valid pulsed while busy mid-word -> data_ready=0, word ignored, current word output unaltered.
